// File: rtl/enemy_spawn_scheduler.sv
// Round-robin spawn arbiter: shares one spawn resource among enemy slots with a score-scaled cooldown.
// The grant is gated live in S_GRANT so a withdrawn request, a pause or a reset in that cycle suppresses the pulse.
module enemy_spawn_scheduler #(
  parameter int          NUM_ENEMIES = 4,
  parameter int          TICK_CYCLES = 25000000,
  parameter int          X_MAX       = 152,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [7:0]             score,
  input  logic [NUM_ENEMIES-1:0] spawnReq,
  output logic [NUM_ENEMIES-1:0] spawnGrant,
  output logic [7:0]             spawnX,
  output logic [2:0]             spawnHealth,
  output logic                   busy
);

  localparam int            IW        = $clog2(NUM_ENEMIES);
  localparam int            TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [7:0]    X_LIM     = 8'(X_MAX);
  localparam logic [7:0]    X_WRAP    = 8'(X_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARBITRATE,
    S_GRANT,
    S_COOLDOWN
  } state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_last;
  logic [IW-1:0]           r_idx;
  logic [TW-1:0]           r_tick;
  logic [1:0]              r_gap;
  logic [15:0]             r_lfsr;
  logic [7:0]              r_x;
  logic [7:0]              r_x_prev;
  logic [2:0]              r_health;
  logic [2:0]              r_health_prev;

  logic                    w_found;
  logic [IW-1:0]           w_pick;
  logic                    w_fb;
  logic [7:0]              w_lfsr_lo;
  logic [7:0]              w_x_next;
  logic [2:0]              w_health_next;
  logic [1:0]              w_gap_next;
  logic                    w_grant_ok;
  logic [NUM_ENEMIES-1:0]  w_onehot;

  // Search starts one past the last winner so persistent requesters rotate fairly.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    for (int k = 1; k <= NUM_ENEMIES; k++) begin
      if (!w_found && spawnReq[(int'(r_last) + k) % NUM_ENEMIES]) begin
        w_found = 1'b1;
        w_pick  = IW'((int'(r_last) + k) % NUM_ENEMIES);
      end
    end
  end

  // Fibonacci taps 16,14,13,11 in right-shift form.
  assign w_fb      = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_lfsr_lo = r_lfsr[7:0];
  assign w_x_next  = (w_lfsr_lo <= X_LIM) ? w_lfsr_lo : (w_lfsr_lo - X_WRAP);

  always_comb begin
    w_health_next = 3'd1;
    w_gap_next    = 2'd3;
    if (score > 8'd30) begin
      w_health_next = 3'd3;
      w_gap_next    = 2'd1;
    end else if (score >= 8'd10) begin
      w_health_next = 3'd2;
      w_gap_next    = 2'd2;
    end
  end

  assign w_onehot   = {{(NUM_ENEMIES-1){1'b0}}, 1'b1} << r_idx;
  assign w_grant_ok = (r_state == S_GRANT) && enable && !reset && spawnReq[r_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last        <= IW'(NUM_ENEMIES - 1);
      r_idx         <= '0;
      r_tick        <= '0;
      r_gap         <= 2'd0;
      r_lfsr        <= LFSR_SEED;
      r_x           <= 8'd0;
      r_x_prev      <= 8'd0;
      r_health      <= 3'd1;
      r_health_prev <= 3'd1;
    end else begin
      if (enable) begin
        r_lfsr <= {w_fb, r_lfsr[15:1]};
      end
      case (r_state)
        S_IDLE: begin
          if (enable && |spawnReq) begin
            r_state <= S_ARBITRATE;
          end
        end
        S_ARBITRATE: begin
          if (w_found) begin
            r_idx         <= w_pick;
            r_x_prev      <= r_x;
            r_health_prev <= r_health;
            r_x           <= w_x_next;
            r_health      <= w_health_next;
            r_state       <= S_GRANT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (w_grant_ok) begin
            r_last  <= r_idx;
            r_gap   <= w_gap_next;
            r_tick  <= '0;
            r_state <= S_COOLDOWN;
          end else begin
            // Nothing was handed out, so the slot outputs go back to what was last granted.
            r_x      <= r_x_prev;
            r_health <= r_health_prev;
            r_state  <= S_IDLE;
          end
        end
        S_COOLDOWN: begin
          if (enable) begin
            if (r_tick == TICK_LAST) begin
              r_tick <= '0;
              r_gap  <= r_gap - 2'd1;
              if (r_gap == 2'd1) begin
                r_state <= S_IDLE;
              end
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign spawnGrant  = w_grant_ok ? w_onehot : '0;
  assign spawnX      = r_x;
  assign spawnHealth = r_health;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Directed bench for enemy_spawn_scheduler with TICK_CYCLES=4, four slots and a reference LFSR.
module tb_enemy_spawn_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] score = 8'd0;
  logic [3:0] spawnReq = 4'b0000;
  logic [3:0] spawnGrant;
  logic [7:0] spawnX;
  logic [2:0] spawnHealth;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  logic [15:0] m_prev;

  enemy_spawn_scheduler #(
    .NUM_ENEMIES(4),
    .TICK_CYCLES(4),
    .X_MAX(152),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .score(score),
    .spawnReq(spawnReq),
    .spawnGrant(spawnGrant),
    .spawnX(spawnX),
    .spawnHealth(spawnHealth),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // m_prev holds the LFSR value seen by the most recent edge, i.e. the one latched in S_ARBITRATE.
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    if (reset) m_lfsr <= 16'hACE1;
    else if (enable) m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  function automatic logic [7:0] fold(input logic [7:0] v);
    return (v <= 8'd152) ? v : (v - 8'd153);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    #2;
    checks++;
    if (spawnGrant !== 4'b0000 || spawnX !== 8'd0 || spawnHealth !== 3'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got grant=%b x=%0d h=%0d busy=%b want 0000 0 1 0", spawnGrant, spawnX, spawnHealth, busy);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_x;
    int n;
    int extra;
    step(); reset = 1'b0; enable = 1'b1; score = 8'd0; spawnReq = 4'b0001;
    step(); #2;
    checks++;
    if (spawnGrant !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_arb: got grant=%b busy=%b want 0000 1", spawnGrant, busy);
    end
    step(); #2;
    exp_x = fold(m_prev[7:0]);
    checks++;
    if (spawnGrant !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: got %b want 0001", spawnGrant);
    end
    checks++;
    if (spawnHealth !== 3'd1 || spawnX !== exp_x) begin
      errors++;
      $display("FAIL single_payload: got x=%0d h=%0d want x=%0d h=1", spawnX, spawnHealth, exp_x);
    end
    step(); spawnReq = 4'b0000; #2;
    n = 0;
    extra = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (spawnGrant !== 4'b0000) extra++;
      step(); #2;
    end
    checks++;
    if (n != 12 || extra != 0) begin
      errors++;
      $display("FAIL single_cooldown: got %0d busy cycles %0d grants want 12 0", n, extra);
    end
    checks++;
    if (spawnX !== exp_x || spawnHealth !== 3'd1) begin
      errors++;
      $display("FAIL single_hold: got x=%0d h=%0d want x=%0d h=1", spawnX, spawnHealth, exp_x);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    int gcyc [5];
    int n;
    int c;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    step(); reset = 1'b1; spawnReq = 4'b0000;
    step(); reset = 1'b0; enable = 1'b1; score = 8'd0; spawnReq = 4'b1111;
    n = 0;
    c = 0;
    while (n < 5 && c < 120) begin
      step(); c++; #2;
      if (spawnGrant !== 4'b0000) begin
        checks++;
        if (spawnGrant !== exp_g[n]) begin
          errors++;
          $display("FAIL rr_grant%0d: got %b want %b", n, spawnGrant, exp_g[n]);
        end
        gcyc[n] = c;
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d grants want 5", n);
    end else begin
      checks++;
      if (gcyc[0] != 2) begin
        errors++;
        $display("FAIL rr_latency: got %0d cycles want 2", gcyc[0]);
      end
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (gcyc[i] - gcyc[i-1] != 15) begin
          errors++;
          $display("FAIL rr_spacing%0d: got %0d cycles want 15", i, gcyc[i] - gcyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_score();
    logic [7:0] sc [3];
    logic [2:0] eh [3];
    int         es [3];
    int gcyc [2];
    logic [2:0] gh [2];
    int n;
    int c;
    sc = '{8'd10, 8'd31, 8'd30};
    eh = '{3'd2, 3'd3, 3'd2};
    es = '{11, 7, 11};
    for (int t = 0; t < 3; t++) begin
      step(); reset = 1'b1; spawnReq = 4'b0000;
      step(); reset = 1'b0; enable = 1'b1; score = sc[t]; spawnReq = 4'b1111;
      n = 0;
      c = 0;
      while (n < 2 && c < 60) begin
        step(); c++; #2;
        if (spawnGrant !== 4'b0000) begin
          gcyc[n] = c;
          gh[n] = spawnHealth;
          n++;
        end
      end
      checks++;
      if (n != 2) begin
        errors++;
        $display("FAIL score%0d_count: got %0d grants want 2", sc[t], n);
      end else begin
        checks++;
        if (gh[0] !== eh[t] || gh[1] !== eh[t]) begin
          errors++;
          $display("FAIL score%0d_health: got %0d,%0d want %0d", sc[t], gh[0], gh[1], eh[t]);
        end
        checks++;
        if (gcyc[1] - gcyc[0] != es[t]) begin
          errors++;
          $display("FAIL score%0d_spacing: got %0d want %0d", sc[t], gcyc[1] - gcyc[0], es[t]);
        end
      end
    end
  endtask

  task automatic test_score_change();
    int gcyc [3];
    logic [2:0] gh [3];
    int n;
    int c;
    step(); reset = 1'b1; spawnReq = 4'b0000;
    step(); reset = 1'b0; enable = 1'b1; score = 8'd0; spawnReq = 4'b1111;
    n = 0;
    c = 0;
    while (n < 3 && c < 80) begin
      step(); c++;
      if (n == 1 && score == 8'd0) score = 8'd31;
      #2;
      if (spawnGrant !== 4'b0000) begin
        gcyc[n] = c;
        gh[n] = spawnHealth;
        n++;
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL scorechg_count: got %0d grants want 3", n);
    end else begin
      checks++;
      if (gh[0] !== 3'd1 || gh[1] !== 3'd3 || gh[2] !== 3'd3) begin
        errors++;
        $display("FAIL scorechg_health: got %0d,%0d,%0d want 1,3,3", gh[0], gh[1], gh[2]);
      end
      checks++;
      if (gcyc[1] - gcyc[0] != 15 || gcyc[2] - gcyc[1] != 7) begin
        errors++;
        $display("FAIL scorechg_spacing: got %0d,%0d want 15,7", gcyc[1] - gcyc[0], gcyc[2] - gcyc[1]);
      end
    end
  endtask

  task automatic test_drop();
    step(); reset = 1'b1; spawnReq = 4'b0000;
    step(); reset = 1'b0; enable = 1'b1; score = 8'd31; spawnReq = 4'b0010;
    step(); #2;
    step(); spawnReq = 4'b0000; #2;
    checks++;
    if (spawnGrant !== 4'b0000) begin
      errors++;
      $display("FAIL drop_in_grant_pulse: got %b want 0000", spawnGrant);
    end
    step(); #2;
    checks++;
    if (busy !== 1'b0 || spawnX !== 8'd0 || spawnHealth !== 3'd1) begin
      errors++;
      $display("FAIL drop_revert: got busy=%b x=%0d h=%0d want 0 0 1", busy, spawnX, spawnHealth);
    end
    step(); spawnReq = 4'b0100;
    step(); spawnReq = 4'b0000; #2;
    step(); #2;
    checks++;
    if (busy !== 1'b0 || spawnGrant !== 4'b0000) begin
      errors++;
      $display("FAIL drop_in_arb: got busy=%b grant=%b want 0 0000", busy, spawnGrant);
    end
    step(); spawnReq = 4'b1111;
    step();
    step(); #2;
    checks++;
    if (spawnGrant !== 4'b0001 || spawnX !== fold(m_prev[7:0])) begin
      errors++;
      $display("FAIL drop_lastgrant: got grant=%b x=%0d want 0001 x=%0d", spawnGrant, spawnX, fold(m_prev[7:0]));
    end
  endtask

  task automatic test_enable();
    int n;
    int k;
    step(); reset = 1'b1; spawnReq = 4'b0000;
    step(); reset = 1'b0; enable = 1'b1; score = 8'd0; spawnReq = 4'b0001;
    step(); #2;
    step(); #2;
    checks++;
    if (spawnGrant !== 4'b0001) begin
      errors++;
      $display("FAIL pause_first_grant: got %b want 0001", spawnGrant);
    end
    step(); spawnReq = 4'b0000; #2;
    n = 0;
    k = 3;
    while (busy === 1'b1 && n < 60) begin
      n++;
      step(); k++;
      enable = (k >= 6 && k <= 10) ? 1'b0 : 1'b1;
      #2;
    end
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL pause_cooldown: got %0d busy cycles want 17", n);
    end
    step(); enable = 1'b0; spawnReq = 4'b1111;
    step();
    step(); #2;
    checks++;
    if (busy !== 1'b0 || spawnGrant !== 4'b0000) begin
      errors++;
      $display("FAIL pause_idle_hold: got busy=%b grant=%b want 0 0000", busy, spawnGrant);
    end
    step(); enable = 1'b1;
    step(); #2;
    step(); enable = 1'b0; #2;
    checks++;
    if (spawnGrant !== 4'b0000) begin
      errors++;
      $display("FAIL pause_in_grant: got %b want 0000", spawnGrant);
    end
    step(); enable = 1'b1; #2;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL pause_grant_cancel: got busy=%b want 0", busy);
    end
    step(); #2;
    step(); #2;
    checks++;
    if (spawnGrant !== 4'b0010 || spawnX !== fold(m_prev[7:0])) begin
      errors++;
      $display("FAIL pause_resume: got grant=%b x=%0d want 0010 x=%0d", spawnGrant, spawnX, fold(m_prev[7:0]));
    end
  endtask

  task automatic test_reset_mid();
    step(); reset = 1'b1; spawnReq = 4'b0000;
    step(); reset = 1'b0; enable = 1'b1; score = 8'd31; spawnReq = 4'b1111;
    step(); #2;
    step(); reset = 1'b1; #2;
    checks++;
    if (spawnGrant !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_grant: got %b want 0000", spawnGrant);
    end
    step(); reset = 1'b0; #2;
    checks++;
    if (busy !== 1'b0 || spawnX !== 8'd0 || spawnHealth !== 3'd1 || spawnGrant !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_values: got busy=%b x=%0d h=%0d grant=%b want 0 0 1 0000", busy, spawnX, spawnHealth, spawnGrant);
    end
    step(); #2;
    step(); #2;
    checks++;
    if (spawnGrant !== 4'b0001 || spawnHealth !== 3'd3 || spawnX !== fold(m_prev[7:0])) begin
      errors++;
      $display("FAIL reset_mid_regrant: got grant=%b h=%0d x=%0d want 0001 3 %0d", spawnGrant, spawnHealth, spawnX, fold(m_prev[7:0]));
    end
  endtask

  task automatic test_spawn_x();
    int ng;
    int c;
    logic [7:0] ex;
    step(); reset = 1'b1; spawnReq = 4'b0000;
    step(); reset = 1'b0; enable = 1'b1; score = 8'd31; spawnReq = 4'b1111;
    ng = 0;
    c = 0;
    while (ng < 1000 && c < 7100) begin
      step(); c++; #2;
      if (spawnGrant !== 4'b0000) begin
        ex = fold(m_prev[7:0]);
        checks++;
        if (spawnX !== ex) begin
          errors++;
          $display("FAIL spawnx_value%0d: got %0d want %0d (lfsr low %0d)", ng, spawnX, ex, m_prev[7:0]);
        end
        checks++;
        if (spawnX > 8'd152) begin
          errors++;
          $display("FAIL spawnx_range%0d: got %0d want <= 152", ng, spawnX);
        end
        ng++;
      end
    end
    checks++;
    if (ng != 1000) begin
      errors++;
      $display("FAIL spawnx_count: got %0d grants want 1000", ng);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_score();
    test_score_change();
    test_drop();
    test_enable();
    test_reset_mid();
    test_spawn_x();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
